// File: rtl/tpu_pkg.sv
// tpu_pkg: shared writeback FSM states, default widths and requant helpers (round-shift, saturate)
package tpu_pkg;
  localparam int NUM_CH_D = 3;
  localparam int ACC_W_D = 24;
  localparam int DATA_W_D = 8;
  localparam int ADDR_W_D = 8;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} wb_state_e;
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] v, input logic [4:0] sh);
    return sh == 5'd0 ? v : (v + (64'sd1 <<< (sh - 5'd1))) >>> sh;
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/wb_requant.sv
// wb_requant: combinational requant of one signed accumulator (acc_i, shift_i, relu_i) to a saturated DATA_W element (q_o)
module wb_requant
  import tpu_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic        [4:0]        shift_i,
  input  logic                     relu_i,
  output logic signed [DATA_W-1:0] q_o
);
  logic signed [63:0] r, c;
  always_comb begin
    r = round_shr(64'(acc_i), shift_i);
    c = sat(relu_i && r < 0 ? 64'sd0 : r, DATA_W);
    q_o = DATA_W'(c);
  end
endmodule

// File: rtl/ofmap_writeback.sv
// ofmap_writeback: takes NUM_CH-wide accumulator beats (in_valid/in_ready/in_data), requantises them and writes bytes tile-major to the unified buffer (wr_en/wr_addr/wr_data); ctrl_start+cfg_* launch a job, busy/flag_done report it
module ofmap_writeback
  import tpu_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_D,
  parameter int ACC_W = ACC_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ctrl_start,
  input  logic [ADDR_W-1:0]       cfg_base_addr,
  input  logic [15:0]             cfg_num_pixels,
  input  logic [7:0]              cfg_num_tiles,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*ACC_W-1:0] in_data,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    flag_done
);
  localparam int CW = $clog2(NUM_CH) < 1 ? 1 : $clog2(NUM_CH);
  wb_state_e state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [15:0] pix_q, pix_d, npix_q;
  logic [7:0] tile_q, tile_d, ntile_q;
  logic [ADDR_W-1:0] base_q, beat_q, beat_d;
  logic [4:0] shift_q;
  logic relu_q, last_q, last_d, last_ch, xfer, pix_wrap;
  logic [DATA_W-1:0] buf_q [NUM_CH];
  logic [DATA_W-1:0] buf_d [NUM_CH];
  logic [DATA_W-1:0] rq [NUM_CH];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_rq
    wb_requant #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_rq (
      .acc_i(in_data[i*ACC_W +: ACC_W]),
      .shift_i(shift_q),
      .relu_i(relu_q),
      .q_o(rq[i])
    );
  end
  always_comb begin
    last_ch = ch_q == CW'(NUM_CH - 1);
    in_ready = state_q == LOAD || (state_q == WRITE && last_ch && !last_q);
    xfer = in_valid && in_ready;
    wr_en = state_q == WRITE;
    wr_addr = wr_en ? beat_q + ADDR_W'(ch_q) : '0;
    wr_data = wr_en ? buf_q[ch_q] : '0;
    busy = state_q != IDLE;
    flag_done = state_q == DONE;
    pix_wrap = pix_q == npix_q - 16'd1;
  end
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    pix_d = pix_q;
    tile_d = tile_q;
    beat_d = beat_q;
    last_d = last_q;
    buf_d = buf_q;
    if (state_q == WRITE) ch_d = last_ch ? '0 : ch_q + 1'b1;
    if (xfer) begin
      buf_d = rq;
      beat_d = base_q + ADDR_W'(32'(pix_q) * NUM_CH * 32'(ntile_q) + 32'(tile_q) * NUM_CH);
      last_d = pix_wrap && tile_q == ntile_q - 8'd1;
      pix_d = pix_wrap ? 16'd0 : pix_q + 16'd1;
      tile_d = pix_wrap ? tile_q + 8'd1 : tile_q;
      ch_d = '0;
    end
    case (state_q)
      IDLE: if (ctrl_start) begin
        state_d = cfg_num_pixels == 16'd0 || cfg_num_tiles == 8'd0 ? DONE : LOAD;
        pix_d = '0;
        tile_d = '0;
        last_d = 1'b0;
      end
      LOAD: state_d = xfer ? WRITE : LOAD;
      WRITE: if (last_ch) state_d = last_q ? DONE : xfer ? WRITE : LOAD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      pix_q <= '0;
      tile_q <= '0;
      beat_q <= '0;
      last_q <= 1'b0;
      buf_q <= '{default: '0};
      base_q <= '0;
      npix_q <= '0;
      ntile_q <= '0;
      shift_q <= '0;
      relu_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      pix_q <= pix_d;
      tile_q <= tile_d;
      beat_q <= beat_d;
      last_q <= last_d;
      buf_q <= buf_d;
      if (state_q == IDLE && ctrl_start) begin
        base_q <= cfg_base_addr;
        npix_q <= cfg_num_pixels;
        ntile_q <= cfg_num_tiles;
        shift_q <= cfg_shift;
        relu_q <= cfg_relu;
      end
    end
  end
endmodule

// File: tb/tb_ofmap_writeback.sv
// tb_ofmap_writeback: directed table-driven bench for ofmap_writeback
module tb_ofmap_writeback;
  localparam int NC = 3;
  localparam int AW = 24;
  typedef struct {
    int sh;
    int relu;
    int acc;
    int exp;
  } rq_vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl_start = 1'b0;
  logic [7:0] cfg_base_addr = '0;
  logic [15:0] cfg_num_pixels = '0;
  logic [7:0] cfg_num_tiles = '0;
  logic [4:0] cfg_shift = '0;
  logic cfg_relu = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [NC*AW-1:0] in_data = '0;
  logic wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic busy;
  logic flag_done;
  int pass_n = 0, tot_n = 0;
  int wa[$], wd[$], ea[$], ed[$];
  int done_cnt = 0, ready_cnt = 0, cyc = 0, first_wr = -1, last_wr = -1;
  logic [NC*AW-1:0] beats[$];
  rq_vec_t tv[14];
  ofmap_writeback dut (
    .clk(clk), .rst(rst), .ctrl_start(ctrl_start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_pixels(cfg_num_pixels), .cfg_num_tiles(cfg_num_tiles), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .flag_done(flag_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (wr_en) begin
        wa.push_back(int'(wr_addr));
        wd.push_back(int'($signed(wr_data)));
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (flag_done) done_cnt++;
      if (in_ready) ready_cnt++;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
  task automatic chk(input string nm, input int idx, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
  endtask
  function automatic logic [NC*AW-1:0] pack(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction
  task automatic mk(input int base, input int pix, input int tiles, input int mul);
    beats.delete();
    ea.delete();
    ed.delete();
    for (int t = 0; t < tiles; t++)
      for (int p = 0; p < pix; p++) begin
        beats.push_back(pack(mul*(t*pix+p)+1, mul*(t*pix+p)+2, mul*(t*pix+p)+3));
        for (int c = 0; c < NC; c++) begin
          ea.push_back((base + p*NC*tiles + t*NC + c) % 256);
          ed.push_back(mul*(t*pix+p) + c + 1);
        end
      end
  endtask
  task automatic clear_mon();
    wa.delete();
    wd.delete();
    first_wr = -1;
    last_wr = -1;
    ready_cnt = 0;
  endtask
  task automatic run_job(input int base, input int pix, input int tiles, input int sh, input int relu, input int mid);
    int k, n, bound, d0;
    logic hs;
    n = beats.size();
    k = 0;
    bound = 0;
    d0 = done_cnt;
    clear_mon();
    cfg_base_addr = 8'(base);
    cfg_num_pixels = 16'(pix);
    cfg_num_tiles = 8'(tiles);
    cfg_shift = 5'(sh);
    cfg_relu = relu != 0;
    ctrl_start = 1'b1;
    @(posedge clk);
    #1 ctrl_start = 1'b0;
    in_valid = 1'b1;
    in_data = beats[0];
    while (k < n && bound < n*NC + 20) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1 ctrl_start = 1'b0;
      bound++;
      if (hs) begin
        k++;
        if (k < n) in_data = beats[k];
        else in_valid = 1'b0;
        if (mid != 0 && k == 1) begin
          cfg_base_addr = 8'd77;
          cfg_num_pixels = 16'd1;
          ctrl_start = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    ctrl_start = 1'b0;
    chk("beats_accepted", 0, k, n);
    bound = 0;
    while (done_cnt == d0 && bound < 60) begin
      @(negedge clk);
      bound++;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 0, done_cnt - d0, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic check_writes();
    chk("wr_count", 0, wa.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      chk("wr_addr", i, wa[i], ea[i]);
      chk("wr_data", i, wd[i], ed[i]);
    end
  endtask
  initial begin
    int d0, b;
    tv[0] = '{4, 0, 24, 2};
    tv[1] = '{4, 0, -24, -1};
    tv[2] = '{4, 0, 40000, 127};
    tv[3] = '{4, 0, -40000, -128};
    tv[4] = '{4, 1, -24, 0};
    tv[5] = '{0, 0, -5, -5};
    tv[6] = '{0, 0, 200, 127};
    tv[7] = '{1, 0, 3, 2};
    tv[8] = '{1, 0, -3, -1};
    tv[9] = '{2, 0, -6, -1};
    tv[10] = '{0, 1, -1, 0};
    tv[11] = '{3, 0, 100, 13};
    tv[12] = '{31, 0, -8388608, 0};
    tv[13] = '{0, 0, -8388608, -128};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 0, int'(in_ready), 0);
    chk("rst_wr_en", 0, int'(wr_en), 0);
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_flag_done", 0, int'(flag_done), 0);
    chk("rst_wr_addr", 0, int'(wr_addr), 0);
    chk("rst_wr_data", 0, int'(wr_data), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mk(25, 9, 1, 0);
    run_job(25, 9, 1, 0, 0, 0);
    check_writes();
    chk("ready_cycles", 0, ready_cnt, 9);
    chk("wr_contiguous", 0, last_wr - first_wr + 1, 27);
    mk(0, 2, 2, 10);
    run_job(0, 2, 2, 0, 0, 0);
    check_writes();
    mk(250, 4, 1, 10);
    run_job(250, 4, 1, 0, 0, 1);
    check_writes();
    for (int i = 0; i < 14; i++) begin
      beats.delete();
      beats.push_back(pack(tv[i].acc, tv[i].acc, tv[i].acc));
      run_job(0, 1, 1, tv[i].sh, tv[i].relu, 0);
      chk("rq_count", i, wd.size(), 3);
      for (int c = 0; c < 3 && c < wd.size(); c++) chk("rq_data", i, wd[c], tv[i].exp);
    end
    clear_mon();
    cfg_num_pixels = 16'd0;
    cfg_num_tiles = 8'd3;
    ctrl_start = 1'b1;
    @(negedge clk);
    chk("p0_done_early", 0, int'(flag_done), 0);
    @(posedge clk);
    #1 ctrl_start = 1'b0;
    @(negedge clk);
    chk("p0_done", 0, int'(flag_done), 1);
    chk("p0_busy", 0, int'(busy), 1);
    @(negedge clk);
    chk("p0_done_drop", 0, int'(flag_done), 0);
    chk("p0_writes", 0, wa.size(), 0);
    @(posedge clk);
    #1;
    d0 = done_cnt;
    cfg_num_pixels = 16'd5;
    cfg_num_tiles = 8'd0;
    ctrl_start = 1'b1;
    @(posedge clk);
    #1 ctrl_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t0_done", 0, done_cnt - d0, 1);
    chk("t0_writes", 0, wa.size(), 0);
    @(posedge clk);
    #1;
    clear_mon();
    d0 = done_cnt;
    cfg_base_addr = 8'd0;
    cfg_num_pixels = 16'd4;
    cfg_num_tiles = 8'd1;
    cfg_shift = 5'd0;
    cfg_relu = 1'b0;
    ctrl_start = 1'b1;
    @(posedge clk);
    #1 ctrl_start = 1'b0;
    in_valid = 1'b1;
    in_data = pack(5, 6, 7);
    b = 0;
    while (!(wa.size() == 3 && wr_en) && b < 40) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("mid_reached", 0, int'(b < 40), 1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_wr_en", 0, int'(wr_en), 0);
    chk("mid_rst_busy", 0, int'(busy), 0);
    chk("mid_rst_in_ready", 0, int'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_no_done", 0, done_cnt - d0, 0);
    chk("mid_no_writes", 0, wa.size(), 3);
    @(posedge clk);
    #1;
    beats.delete();
    beats.push_back(pack(10, -10, 7));
    beats.push_back(pack(1, 2, -3));
    ea = '{100, 101, 102, 103, 104, 105};
    ed = '{5, -5, 4, 1, 1, -1};
    run_job(100, 2, 1, 1, 0, 0);
    check_writes();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
